// File: rtl/sub_8bit_serial_if.sv
// Start/done request bus for the bit-serial 8-bit subtractor.
interface sub_8bit_serial_if;
  localparam int unsigned WIDTH = 8;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] bout;

  modport master (output start, a, b, bin, input busy, done, d, bout);
  modport slave  (input start, a, b, bin, output busy, done, d, bout);
endinterface

// File: rtl/sub_8bit_serial.sv
// Bit-serial 8-bit subtractor: A - B - bin, one bit per clock, LSB first,
// with a per-bit borrow vector published alongside the difference.
module sub_8bit_serial (
  input  logic                    clk,
  input  logic                    rst,
  sub_8bit_serial_if.slave        bus
);
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] ra, ra_n, rb, rb_n;
  logic             br, br_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] sd, sd_n, sb, sb_n;
  logic [WIDTH-1:0] d, d_n, bout, bout_n;
  logic             busy, busy_n, done, done_n;

  // Current bit slice of the full-subtractor chain.
  logic x, y, s, n;
  assign x = ra[idx];
  assign y = rb[idx];
  assign s = x ^ y ^ br;
  assign n = (~x & y) | (~(x ^ y) & br);

  assign bus.d    = d;
  assign bus.bout = bout;
  assign bus.busy = busy;
  assign bus.done = done;

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      br    <= 1'b0;
      idx   <= '0;
      sd    <= '0;
      sb    <= '0;
      d     <= '0;
      bout  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ra    <= ra_n;
      rb    <= rb_n;
      br    <= br_n;
      idx   <= idx_n;
      sd    <= sd_n;
      sb    <= sb_n;
      d     <= d_n;
      bout  <= bout_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state and next-output logic; d/bout only move on the completion edge.
  always_comb begin
    state_n = state;
    ra_n    = ra;
    rb_n    = rb;
    br_n    = br;
    idx_n   = idx;
    sd_n    = sd;
    sb_n    = sb;
    d_n     = d;
    bout_n  = bout;
    busy_n  = busy;
    done_n  = done;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          ra_n    = bus.a;
          rb_n    = bus.b;
          br_n    = bus.bin;
          idx_n   = '0;
          sd_n    = '0;
          sb_n    = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          state_n = RUN;
        end else begin
          busy_n  = 1'b0;
          done_n  = 1'b0;
          state_n = IDLE;
        end
      end
      RUN: begin
        sd_n[idx] = s;
        sb_n[idx] = n;
        br_n      = n;
        if (idx == IDX_W'(WIDTH - 1)) begin
          d_n     = sd_n;
          bout_n  = sb_n;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sub_8bit_serial.sv
// Directed plus random checks of the bit-serial subtractor against an
// arithmetic reference model.
module tb_sub_8bit_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub_8bit_serial_if bus();

  sub_8bit_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] held_d    = 8'h00;
  logic [7:0] held_bout = 8'h00;

  // Reference difference: plain modular arithmetic.
  function automatic logic [7:0] ref_d(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int ai, bi, ci;
    ai = a; bi = b; ci = bin;
    return 8'(ai - bi - ci);
  endfunction

  // Reference borrows: bit i borrows out when the low i+1 bits of a are
  // smaller than the low i+1 bits of b plus the incoming borrow.
  function automatic logic [7:0] ref_bout(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [7:0] r;
    int ai, bi, ci, m;
    ai = a; bi = b; ci = bin;
    for (int i = 0; i < 8; i++) begin
      m = 1 << (i + 1);
      r[i] = ((ai % m) < ((bi % m) + ci));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full request: accept, watch the hold window, check latency and result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_hold_d"}, 32'(bus.d), 32'(held_d));
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd8);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_d"}, 32'(bus.d), 32'(ref_d(a, b, bin)));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(ref_bout(a, b, bin)));
    held_d    = ref_d(a, b, bin);
    held_bout = ref_bout(a, b, bin);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_d_hold_idle"}, 32'(bus.d), 32'(held_d));
  endtask

  initial begin
    int cyc, gap, pulses, dones;
    logic [7:0] ca, cb;
    logic cbin;

    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.bin = 1'b0;

    // Reset state
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_d",    32'(bus.d),    32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(8'h50, 8'h20, 1'b0, "p50_20");
    chk("p50_20_const_d", 32'(held_d), 32'h30);
    run_op(8'h00, 8'h01, 1'b0, "under");
    run_op(8'h80, 8'h80, 1'b1, "eq_bin");
    run_op(8'hFF, 8'h00, 1'b0, "ff_00");
    run_op(8'h00, 8'hFF, 1'b1, "max_borrow");

    // Start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h50; bus.b = 8'h20; bus.bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (cyc == 2) begin
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("ign_latency", 32'(cyc), 32'd8);
    chk("ign_d", 32'(bus.d), 32'h30);
    chk("ign_bout", 32'(bus.bout), 32'h20);
    held_d = 8'h30; held_bout = 8'h20;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("ign_no_second_done", 32'(dones), 32'd0);
    chk("ign_idle_busy", 32'(bus.busy), 32'd0);

    // Random operands
    for (int i = 0; i < 10; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), "rand");

    // Start held high: back-to-back results 9 cycles apart
    ca = 8'($urandom); cb = 8'($urandom); cbin = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ca; bus.b = cb; bus.bin = cbin;
    @(posedge clk);
    gap = -1;
    pulses = 0;
    for (int t = 0; t < 80 && pulses < 5; t++) begin
      @(negedge clk);
      gap++;
      if (bus.done === 1'b1) begin
        chk("b2b_gap", 32'(gap), (pulses == 0) ? 32'd8 : 32'd9);
        chk("b2b_d", 32'(bus.d), 32'(ref_d(ca, cb, cbin)));
        chk("b2b_bout", 32'(bus.bout), 32'(ref_bout(ca, cb, cbin)));
        held_d = ref_d(ca, cb, cbin);
        held_bout = ref_bout(ca, cb, cbin);
        pulses++;
        ca = 8'($urandom); cb = 8'($urandom); cbin = 1'($urandom);
        bus.a = ca; bus.b = cb; bus.bin = cbin;
        gap = 0;
      end else begin
        chk("b2b_stable_d", 32'(bus.d), 32'(held_d));
        chk("b2b_stable_bout", 32'(bus.bout), 32'(held_bout));
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.bin = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd5);
    @(negedge clk);
    chk("b2b_end_done", 32'(bus.done), 32'd0);
    chk("b2b_end_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h50; bus.b = 8'h20; bus.bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_d",    32'(bus.d),    32'd0);
    chk("arst_bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    held_d = 8'h00; held_bout = 8'h00;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    chk("arst_no_done", 32'(dones), 32'd0);
    run_op(8'($urandom), 8'($urandom), 1'($urandom), "post_rst");
    run_op(8'h50, 8'h20, 1'b0, "post_rst_dir");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
